// File: rtl/fetch_queue_if.sv
// Bundle between the fetch queue, instruction memory port A and the CPU core.
// The master modport is the fetch queue; the slave modport is its environment
// (memory model plus consumer). Handshake: a word moves from the queue to the
// core on every rising edge where instr_valid and instr_ready are both 1; while
// instr_valid=1 and instr_ready=0, instr and instr_pc hold steady.
interface fetch_queue_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Core-side control
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    // Memory port A
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // Instruction stream to the core
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic [CNT_W-1:0]  count;

    modport master (
        input  redirect,
        input  redirect_pc,
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        output count
    );

    modport slave (
        output redirect,
        output redirect_pc,
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        input  count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues reads to a
// 1-cycle-latency memory port, buffers returned words with their PCs in a
// DEPTH-entry FIFO and hands them to the core in program order. A redirect
// flushes the FIFO and drops the response of any read still in flight.
module fetch_queue #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] start_pc,
    fetch_queue_if.master     bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    // Fetch state
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;

    // FIFO state; storage is deliberately left unreset
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic has_room;
    logic issue;
    logic push;
    logic head_valid;
    logic pop;

    // A read is only issued when the FIFO can absorb it even if the one
    // already in flight lands first; this credit makes overflow impossible.
    assign has_room   = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight}) < DEPTH_EXT;
    assign issue      = !rst && !bus.redirect && has_room;
    assign push       = inflight && !rst && !bus.redirect;
    assign head_valid = (count_q != '0) && !rst && !bus.redirect;
    assign pop        = head_valid && bus.instr_ready;

    assign bus.mem_rd_en   = issue;
    assign bus.mem_addr    = fetch_pc;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = data_mem[rd_ptr];
    assign bus.instr_pc    = pc_mem[rd_ptr];
    // Occupancy reads as zero while reset is held, even before the first
    // reset edge has cleared the register.
    assign bus.count       = rst ? '0 : count_q;

    // Fetch PC, in-flight tracking and FIFO bookkeeping; reset, then redirect,
    // take priority over normal issue/push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= start_pc;
            inflight    <= 1'b0;
            inflight_pc <= start_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + PC_ONE;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Capture the returning word together with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.mem_rdata;
            pc_mem[wr_ptr]   <= inflight_pc;
        end
    end

    // A landing response must always find a free slot.
    assert property (@(posedge clk) disable iff (rst) push |-> (count_q < DEPTH_CNT));

endmodule
